// File: rtl/phy_jtag_master.sv
// SoC-side JTAG master: one IR+DR access per request, TCK generation and TAP walk.
// Optional feature macro: PHY_JTAG_TRST_EN (drive TRST_N low after reset instead of a 5 x TMS=1 reset).
module phy_jtag_master #(
    parameter int IR_W = 5,
    parameter int DR_W = 32,
    parameter int DIV  = 2,
    localparam int LW  = $clog2(DR_W + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [IR_W-1:0] req_ir,
    input  logic [DR_W-1:0] req_dr,
    input  logic [LW-1:0]   req_len,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DR_W-1:0] rsp_dr,
    output logic            busy,
    output logic            phy_tck,
    output logic            phy_tms,
    output logic            phy_tdi,
    output logic            phy_trst_n,
    input  logic            phy_tdo,
    output logic [3:0]      dbg_state
);

    // Handshakes: a transfer happens on a clk edge where valid && ready; valid holds until then.
    localparam int CW = $clog2(((IR_W > DR_W) ? IR_W : DR_W) + 8);
    localparam int PW = $clog2(2 * DIV);
    localparam logic [PW-1:0] PH_RISE = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * DIV - 1);

    typedef enum logic [3:0] {
        ST_TRST, ST_TAP_RST, ST_IDLE, ST_IR_PRE, ST_IR_SHIFT,
        ST_IR_POST, ST_DR_PRE, ST_DR_SHIFT, ST_DR_POST, ST_RESP
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   bit_cnt, bit_cnt_next;
    logic [PW-1:0]   ph_cnt;
    logic            tck_run;
    logic            period_done, bit_last, start_bit, req_hs, tck_en;
    logic [IR_W-1:0] ir_sh;
    logic [DR_W-1:0] dr_sh;
    logic [LW-1:0]   len_q;

    // Index of the final TCK in each state's sequence.
    function automatic logic [CW-1:0] last_idx(input state_t st, input logic [LW-1:0] len);
        logic [CW-1:0] r;
        case (st)
            ST_TRST:     r = CW'(3);
`ifdef PHY_JTAG_TRST_EN
            ST_TAP_RST:  r = CW'(0);
`else
            ST_TAP_RST:  r = CW'(5);
`endif
            ST_IR_PRE:   r = CW'(3);
            ST_IR_SHIFT: r = CW'(IR_W - 1);
            ST_IR_POST:  r = CW'(1);
            ST_DR_PRE:   r = CW'(2);
            ST_DR_SHIFT: r = CW'(len) - CW'(1);
            ST_DR_POST:  r = CW'(1);
            default:     r = CW'(0);
        endcase
        return r;
    endfunction

    function automatic logic tms_of(input state_t st, input logic [CW-1:0] idx,
                                    input logic [LW-1:0] len);
        logic r;
        case (st)
`ifdef PHY_JTAG_TRST_EN
            ST_TAP_RST:  r = 1'b0;
`else
            ST_TAP_RST:  r = (idx < CW'(5));
`endif
            ST_IR_PRE:   r = (idx < CW'(2));
            ST_IR_SHIFT,
            ST_DR_SHIFT: r = (idx == last_idx(st, len));
            ST_IR_POST,
            ST_DR_PRE,
            ST_DR_POST:  r = (idx == CW'(0));
            default:     r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic is_seq(input state_t st);
        return (st != ST_IDLE) && (st != ST_RESP);
    endfunction

    assign rsp_valid   = (state == ST_RESP);
    assign req_ready   = (state == ST_IDLE) && !rsp_valid;
    assign busy        = (state != ST_IDLE);
    assign dbg_state   = state;
    assign req_hs      = req_valid && req_ready;
    assign period_done = tck_run && (ph_cnt == PH_LAST);
    assign bit_last    = (bit_cnt == last_idx(state, len_q));

`ifdef PHY_JTAG_TRST_EN
    assign tck_en = (state != ST_TRST);
    always_ff @(posedge clk) begin
        if (reset)
            phy_trst_n <= 1'b0;
        else if (state == ST_TRST && period_done && bit_last)
            phy_trst_n <= 1'b1;
    end
`else
    assign tck_en     = 1'b1;
    assign phy_trst_n = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset)
`ifdef PHY_JTAG_TRST_EN
            state <= ST_TRST;
`else
            state <= ST_TAP_RST;
`endif
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        if (period_done) begin
            if (bit_last) begin
                bit_cnt_next = '0;
                case (state)
                    ST_TRST:     state_next = ST_TAP_RST;
                    ST_TAP_RST:  state_next = ST_IDLE;
                    ST_IR_PRE:   state_next = ST_IR_SHIFT;
                    ST_IR_SHIFT: state_next = ST_IR_POST;
                    ST_IR_POST:  state_next = (len_q == '0) ? ST_RESP : ST_DR_PRE;
                    ST_DR_PRE:   state_next = ST_DR_SHIFT;
                    ST_DR_SHIFT: state_next = ST_DR_POST;
                    ST_DR_POST:  state_next = ST_RESP;
                    default:     state_next = state;
                endcase
            end else begin
                bit_cnt_next = bit_cnt + CW'(1);
            end
        end
        case (state)
            ST_IDLE: if (req_hs) state_next = ST_IR_PRE;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: ;
        endcase
        // A new TCK begins right after the previous one, or one cycle after entering a sequence.
        start_bit = is_seq(state_next) && (period_done || (!tck_run && is_seq(state)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tck_run <= 1'b0;
            ph_cnt  <= '0;
            bit_cnt <= '0;
            phy_tck <= 1'b0;
            phy_tms <= 1'b1;
            phy_tdi <= 1'b0;
            ir_sh   <= '0;
            dr_sh   <= '0;
            len_q   <= '0;
            rsp_dr  <= '0;
        end else begin
            bit_cnt <= bit_cnt_next;
            if (req_hs) begin
                ir_sh  <= req_ir;
                dr_sh  <= req_dr;
                len_q  <= (req_len > LW'(DR_W)) ? LW'(DR_W) : req_len;
                rsp_dr <= '0;
            end
            if (start_bit) begin
                tck_run <= 1'b1;
                ph_cnt  <= '0;
                phy_tck <= 1'b0;
                phy_tms <= tms_of(state_next, bit_cnt_next, len_q);
                phy_tdi <= 1'b0;
                if (state_next == ST_IR_SHIFT) begin
                    phy_tdi <= ir_sh[0];
                    ir_sh   <= ir_sh >> 1;
                end
                if (state_next == ST_DR_SHIFT) begin
                    phy_tdi <= dr_sh[0];
                    dr_sh   <= dr_sh >> 1;
                end
            end else if (tck_run) begin
                ph_cnt <= ph_cnt + PW'(1);
                if (ph_cnt == PH_RISE) begin
                    phy_tck <= tck_en;
                    if (state == ST_DR_SHIFT)
                        rsp_dr <= rsp_dr | (DR_W'(phy_tdo) << bit_cnt);
                end
                if (period_done) begin
                    tck_run <= 1'b0;
                    phy_tck <= 1'b0;
                end
            end
        end
    end

endmodule
